// File: rtl/fire_actuator.sv
// fire_actuator: drives siren, sprinkler valve and pump handshake from detector requests,
// with minimum valve dwell, pump-ack timeout and latched FAULT. Optional macro: FIRE_ACT_MUTE_EN.
module fire_actuator #(
  parameter int SIREN_HALF   = 8,
  parameter int VALVE_MIN_ON = 32,
  parameter int ACK_TIMEOUT  = 16,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic alarm,
  input  logic extinguish,
  input  logic pump_ack,
  input  logic mute,
  output logic siren,
  output logic valve_open,
  output logic pump_req,
  output logic fault,
  output logic busy
);

  // state    | meaning
  // IDLE     | no request, all drives off
  // WARN     | alarm only, siren pulsing
  // PUMP_REQ | pump requested, waiting for pump_ack (timer counts up)
  // SPRAY    | valve open, pump running, dwell timer counts down
  // FAULT    | pump failed: siren steady, valve held open, pump released
  typedef enum logic [2:0] {IDLE, WARN, PUMP_REQ, SPRAY, FAULT} state_t;

  localparam logic [CNT_W-1:0] PH_LAST    = CNT_W'(SIREN_HALF - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(VALVE_MIN_ON - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ph, ph_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic             lvl, lvl_nxt;
  logic             pulsing_nxt;
  logic             mute_warn;
  logic             siren_nxt, valve_nxt, pump_nxt, fault_nxt, busy_nxt;

`ifdef FIRE_ACT_MUTE_EN
  assign mute_warn = mute;
`else
  logic unused_mute;
  assign unused_mute = mute;
  assign mute_warn   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (extinguish)  state_nxt = PUMP_REQ;
        else if (alarm)  state_nxt = WARN;
      end
      WARN: begin
        if (extinguish)  state_nxt = PUMP_REQ;
        else if (!alarm) state_nxt = IDLE;
      end
      PUMP_REQ: begin
        // ack takes priority over a simultaneous timeout
        if (pump_ack)             state_nxt = SPRAY;
        else if (!extinguish)     state_nxt = alarm ? WARN : IDLE;
        else if (tmr == ACK_LAST) state_nxt = FAULT;
      end
      SPRAY: begin
        if (!pump_ack)                       state_nxt = FAULT;
        else if (!extinguish && tmr == '0)   state_nxt = alarm ? WARN : IDLE;
      end
      FAULT: begin
        if (!alarm && !extinguish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tmr_nxt = '0;
    if (state_nxt == PUMP_REQ) begin
      tmr_nxt = (state == PUMP_REQ) ? tmr + CNT_W'(1) : '0;
    end else if (state_nxt == SPRAY) begin
      if (state != SPRAY) tmr_nxt = DWELL_LOAD;
      else                tmr_nxt = (tmr == '0) ? '0 : tmr - CNT_W'(1);
    end
  end

  // siren phase restarts only on entry from IDLE; moves among pulsing states keep it
  always_comb begin
    pulsing_nxt = (state_nxt == WARN) || (state_nxt == PUMP_REQ) || (state_nxt == SPRAY);
    ph_nxt      = '0;
    lvl_nxt     = 1'b0;
    if (pulsing_nxt) begin
      if (state == IDLE) begin
        ph_nxt  = '0;
        lvl_nxt = 1'b1;
      end else if (ph == PH_LAST) begin
        ph_nxt  = '0;
        lvl_nxt = ~lvl;
      end else begin
        ph_nxt  = ph + CNT_W'(1);
        lvl_nxt = lvl;
      end
    end else if (state_nxt == FAULT) begin
      ph_nxt  = ph;
      lvl_nxt = lvl;
    end
  end

  always_comb begin
    siren_nxt = (state_nxt == FAULT) ||
                (pulsing_nxt && lvl_nxt && !((state_nxt == WARN) && mute_warn));
    valve_nxt = (state_nxt == SPRAY) || (state_nxt == FAULT);
    pump_nxt  = (state_nxt == PUMP_REQ) || (state_nxt == SPRAY);
    fault_nxt = (state_nxt == FAULT);
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ph         <= '0;
      tmr        <= '0;
      lvl        <= 1'b0;
      siren      <= 1'b0;
      valve_open <= 1'b0;
      pump_req   <= 1'b0;
      fault      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ph         <= ph_nxt;
      tmr        <= tmr_nxt;
      lvl        <= lvl_nxt;
      siren      <= siren_nxt;
      valve_open <= valve_nxt;
      pump_req   <= pump_nxt;
      fault      <= fault_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
